// File: rtl/serial_adder_pkg.sv
// State encoding shared by the bit-serial adder control.
package serial_adder_pkg;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/full_adder.sv
// 1-bit full adder cell: the per-bit arithmetic of the serial adder.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder evaluation per cycle, LSB first,
// with a start/busy/done handshake and registered Sum/Cout.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    // Holds the low WIDTH-1 result bits; the final bit comes straight from the adder.
    logic [WIDTH-2:0] psum;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .A   (a_sh[0]),
        .B   (b_sh[0]),
        .Cin (carry),
        .Sum (fa_sum),
        .Cout(fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            psum  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= fa_cout;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    psum  <= (psum >> 1) | ((WIDTH-1)'(fa_sum) << (WIDTH-2));
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        Sum   <= {fa_sum, psum};
                        Cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed scoreboard bench for serial_adder at WIDTH=8 plus an exhaustive WIDTH=4 sweep.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, cin;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;
    logic       start4, cin4;
    logic [3:0] a4, b4;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int checks   = 0;
    int failures = 0;
    logic [8:0] sb[$];
    logic [4:0] sb4[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Cin(cin),
        .busy(busy), .done(done), .Sum(sum), .Cout(cout)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4),
        .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge while the DUT is idle.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
        a = ia; b = ib; cin = ic; start = 1'b1;
        sb.push_back(9'(ia) + 9'(ib) + 9'(ic));
        @(posedge clk); #1;
        start = 1'b0; a = ~ia; b = ~ib; cin = ~ic;
    endtask

    task automatic wait_done(input string tag, output int busy_cycles);
        int   n;
        logic seen;
        logic [8:0] exp;
        n = 0; seen = 1'b0; busy_cycles = 0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
            else if (busy) busy_cycles++;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk({tag, "_sum"}, 32'(sum), 32'(exp[7:0]));
                chk({tag, "_cout"}, 32'(cout), 32'(exp[8]));
            end else begin
                chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
            end
        end
    endtask

    task automatic run4(input logic [3:0] ia, input logic [3:0] ib, input logic ic);
        int   n;
        logic seen;
        logic [4:0] exp;
        a4 = ia; b4 = ib; cin4 = ic; start4 = 1'b1;
        sb4.push_back(5'(ia) + 5'(ib) + 5'(ic));
        @(posedge clk); #1;
        start4 = 1'b0; a4 = ~ia; b4 = ~ib;
        n = 0; seen = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            if (done4) seen = 1'b1;
        end
        exp = sb4.pop_front();
        checks++;
        assert (seen && {cout4, sum4} === exp) else begin
            failures++;
            $error("FAIL sweep4 a=%0h b=%0h cin=%0b observed=%0h done=%0b expected=%0h",
                   ia, ib, ic, {cout4, sum4}, seen, exp);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int bc;
        int extra;
        rst = 1'b1; start = 1'b0; cin = 1'b0; a = '0; b = '0;
        start4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic add with latency and done-pulse width.
        issue(8'h5A, 8'h33, 1'b0);
        wait_done("basic", bc);
        chk("basic_busy_cycles", 32'(bc), 32'd8);
        @(negedge clk);
        chk("basic_done_clears", 32'(done), 32'd0);
        chk("basic_sum_holds", 32'(sum), 32'h8D);

        @(posedge clk); #1;
        issue(8'hFF, 8'h01, 1'b0);
        wait_done("ff_01", bc);
        @(posedge clk); #1;
        issue(8'hFF, 8'hFF, 1'b1);
        wait_done("ff_ff_c1", bc);
        chk("ff_ff_busy_cycles", 32'(bc), 32'd8);

        // Second start while busy must be ignored.
        @(posedge clk); #1;
        issue(8'h10, 8'h20, 1'b0);
        @(posedge clk); #1;
        a = 8'h7F; b = 8'h7F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_ignore", bc);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("busy_ignore_no_extra", 32'(extra), 32'd0);

        // Asynchronous reset mid-run, then restart on the first released edge.
        @(posedge clk); #1;
        issue(8'h5A, 8'h33, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_sum",  32'(sum),  32'd0);
        chk("async_rst_cout", 32'(cout), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        issue(8'h01, 8'h01, 1'b0);
        wait_done("rst_restart", bc);
        chk("rst_restart_busy_cycles", 32'(bc), 32'd8);

        // Back-to-back: new start accepted during the done cycle.
        @(posedge clk); #1;
        issue(8'h12, 8'h34, 1'b1);
        wait_done("b2b_first", bc);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        sb.push_back(9'h100);
        @(posedge clk); #1;
        start = 1'b0; a = 8'h00; b = 8'h00;
        wait_done("b2b_second", bc);
        chk("b2b_second_busy_cycles", 32'(bc), 32'd8);

        // Exhaustive WIDTH=4 sweep.
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int k = 0; k < 2; k++)
                    run4(4'(i), 4'(j), 1'(k));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
